// File: rtl/irq_pkg.sv
// irq_pkg: shared types and helpers for the external interrupt controller.
// Holds the controller FSM state encoding and a lowest-set-bit encoder.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_e;

  // Index of the lowest set bit; bit 0 is the highest priority.
  function automatic logic [4:0] lsb_idx(input logic [31:0] v);
    logic [4:0] r;
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) r = 5'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_ctrl_sync.sv
// irq_ctrl_sync: multi-flop synchronizer for one asynchronous line.
// Ports: clk, rst_n (sync, active-low), d (async in), q (synced out).
module irq_ctrl_sync #(
  parameter int   STAGES      = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= {STAGES{RESET_VALUE}};
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: edge/level interrupt controller with claim/complete handshake.
// Ports: irq_async/cfg_en/cfg_edge in; irq_req/irq_id/in_service/pending/cpl_err out.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter  int NUM_IRQ     = 8,
  parameter  int SYNC_STAGES = 2,
  localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_async,
  input  logic [NUM_IRQ-1:0] cfg_en,
  input  logic [NUM_IRQ-1:0] cfg_edge,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  input  logic               claim,
  input  logic               complete,
  input  logic [ID_W-1:0]    complete_id,
  output logic               in_service,
  output logic [NUM_IRQ-1:0] pending,
  output logic               cpl_err
);

  logic               rst_n;
  logic [NUM_IRQ-1:0] sync_s;
  logic [NUM_IRQ-1:0] hist_q, hist_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] active;
  logic [31:0]        vec32;
  logic [4:0]         idx;
  state_e             state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               err_q, err_d;

  assign rst_n = ~rst;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
    irq_ctrl_sync #(
      .STAGES     (SYNC_STAGES),
      .RESET_VALUE(1'b0)
    ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (irq_async[i]),
      .q    (sync_s[i])
    );
  end

  always_comb begin
    hist_d  = sync_s;
    rise    = sync_s & ~hist_q;
    active  = pend_q & cfg_en;
    vec32   = '0;
    vec32[NUM_IRQ-1:0] = active;
    idx     = lsb_idx(vec32);
    clr     = '0;
    state_d = state_q;
    id_d    = id_q;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|active) begin
          state_d = REQ;
          id_d    = idx[ID_W-1:0];
        end
      end
      REQ: begin
        // Claim beats a simultaneous withdraw.
        if (claim) begin
          state_d  = SERVICE;
          clr[id_q] = cfg_edge[id_q];
        end else if (!pend_q[id_q]) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (complete && complete_id == id_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (complete && !(state_q == SERVICE && complete_id == id_q))
      err_d = 1'b1;

    // A rise in the claim cycle wins over the clear.
    pend_d = cfg_en & (
      ( cfg_edge & ((pend_q & ~clr) | rise)) |
      (~cfg_edge & sync_s));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      pend_q  <= '0;
      hist_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      pend_q  <= pend_d;
      hist_q  <= hist_d;
      err_q   <= err_d;
    end
  end

  assign irq_req    = (state_q == REQ);
  assign in_service = (state_q == SERVICE);
  assign irq_id     = id_q;
  assign pending    = pend_q;
  assign cpl_err    = err_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: randomized and directed bench for irq_ctrl with a
// cycle-level reference model feeding a scoreboard queue.
module tb_irq_ctrl;

  localparam int N  = 8;
  localparam int SS = 2;

  typedef struct packed {
    logic       req;
    logic [2:0] id;
    logic       insvc;
    logic [7:0] pend;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] irq_async;
  logic [7:0] cfg_en;
  logic [7:0] cfg_edge;
  logic       irq_req;
  logic [2:0] irq_id;
  logic       claim;
  logic       complete;
  logic [2:0] complete_id;
  logic       in_service;
  logic [7:0] pending;
  logic       cpl_err;

  int checks = 0;
  int errors = 0;

  exp_t expq[$];

  // Reference model: mode 0 idle, 1 requesting, 2 servicing.
  int       mode;
  int       mid;
  bit [7:0] mpend;
  bit [7:0] mhist;
  bit       merr;
  bit [7:0] msync[SS];

  irq_ctrl #(.NUM_IRQ(N), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_async  (irq_async),
    .cfg_en     (cfg_en),
    .cfg_edge   (cfg_edge),
    .irq_req    (irq_req),
    .irq_id     (irq_id),
    .claim      (claim),
    .complete   (complete),
    .complete_id(complete_id),
    .in_service (in_service),
    .pending    (pending),
    .cpl_err    (cpl_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("irq_req", int'(irq_req), int'(e.req));
      chk("irq_id", int'(irq_id), int'(e.id));
      chk("in_service", int'(in_service), int'(e.insvc));
      chk("pending", int'(pending), int'(e.pend));
      chk("cpl_err", int'(cpl_err), int'(e.err));
    end
  end

  task automatic model_reset();
    mode  = 0;
    mid   = 0;
    mpend = '0;
    mhist = '0;
    merr  = 1'b0;
    for (int k = 0; k < SS; k++) msync[k] = '0;
  endtask

  task automatic model_tick();
    bit [7:0] s;
    bit [7:0] np;
    int       f;
    if (rst) begin
      model_reset();
      return;
    end
    s  = msync[SS-1];
    np = mpend;
    for (int i = 0; i < N; i++) begin
      if (!cfg_en[i]) np[i] = 1'b0;
      else if (cfg_edge[i]) begin
        if (mode == 1 && claim && mid == i) np[i] = 1'b0;
        if (s[i] && !mhist[i]) np[i] = 1'b1;
      end else np[i] = s[i];
    end
    merr = complete && !(mode == 2 && int'(complete_id) == mid);
    case (mode)
      0: begin
        f = -1;
        for (int i = N - 1; i >= 0; i--)
          if (mpend[i] && cfg_en[i]) f = i;
        if (f >= 0) begin
          mode = 1;
          mid  = f;
        end
      end
      1: begin
        if (claim) mode = 2;
        else if (!mpend[mid]) mode = 0;
      end
      default: begin
        if (complete && int'(complete_id) == mid) mode = 0;
      end
    endcase
    mpend = np;
    mhist = s;
    for (int k = SS - 1; k > 0; k--) msync[k] = msync[k-1];
    msync[0] = irq_async;
  endtask

  // Push the expectation for the current cycle, then advance one edge.
  task automatic step();
    exp_t e;
    if (rst) e = '0;
    else begin
      e.req   = (mode == 1);
      e.id    = 3'(mid);
      e.insvc = (mode == 2);
      e.pend  = mpend;
      e.err   = merr;
    end
    expq.push_back(e);
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_mode(int m, string nm);
    int n;
    n = 0;
    while (mode != m && n < 30) begin
      step();
      n++;
    end
    checks++;
    if (mode != m) begin
      errors++;
      $display("FAIL %s: timeout, mode %0d expected %0d", nm, mode, m);
    end
  endtask

  task automatic do_claim();
    claim = 1'b1;
    step();
    claim = 1'b0;
  endtask

  task automatic do_complete(int id);
    complete    = 1'b1;
    complete_id = 3'(id);
    step();
    complete = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    irq_async   = '0;
    cfg_en      = '0;
    cfg_edge    = '0;
    claim       = 1'b0;
    complete    = 1'b0;
    complete_id = '0;
    model_reset();
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    idle(2);

    // Single edge line 3.
    cfg_en = 8'h08; cfg_edge = 8'h08;
    irq_async[3] = 1'b1;
    idle(3);
    wait_mode(1, "edge3_req");
    do_claim();
    idle(2);
    do_complete(3);
    idle(3);

    // Two simultaneous edges: 2 wins, then 5.
    irq_async = '0; idle(3);
    cfg_en = 8'h24; cfg_edge = 8'h24;
    irq_async = 8'h24;
    wait_mode(1, "pri_req2");
    do_claim(); idle(1);
    do_complete(2);
    wait_mode(1, "pri_req5");
    do_claim(); do_complete(5);
    idle(2);

    // Level line 1: re-request, then withdraw.
    irq_async = '0;
    cfg_en = 8'h02; cfg_edge = 8'h00;
    irq_async[1] = 1'b1;
    wait_mode(1, "lvl_req");
    do_claim(); idle(1);
    do_complete(1);
    wait_mode(1, "lvl_rereq");
    irq_async[1] = 1'b0;
    idle(4);

    // Wrong-ID complete, then complete in IDLE.
    cfg_en = 8'h08; cfg_edge = 8'h08;
    irq_async[3] = 1'b1;
    wait_mode(1, "err_req");
    do_claim(); idle(1);
    do_complete(4); idle(1);
    do_complete(3); idle(1);
    do_complete(3); idle(2);

    // Edge on line 3 landing in the claim cycle.
    irq_async[3] = 1'b0; idle(3);
    irq_async[3] = 1'b1;
    wait_mode(1, "col_req");
    irq_async[3] = 1'b0; idle(3);
    irq_async[3] = 1'b1;
    step(); step();
    do_claim(); idle(1);
    do_complete(3);
    wait_mode(1, "col_rereq");
    do_claim(); do_complete(3);

    // Reset during service, then a disabled toggling line.
    irq_async = '0; idle(3);
    irq_async[3] = 1'b1;
    wait_mode(1, "rst_req");
    do_claim(); idle(1);
    rst = 1'b1; idle(2);
    rst = 1'b0;
    cfg_en = 8'h00;
    for (int i = 0; i < 12; i++) begin
      irq_async[6] = ~irq_async[6];
      step();
    end

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(7) == 0) irq_async[i] = ~irq_async[i];
      if ($urandom_range(63) == 0) begin
        cfg_en   = 8'($urandom);
        cfg_edge = 8'($urandom);
      end
      if (mode == 1) claim = 1'($urandom_range(1));
      else claim = ($urandom_range(15) == 0);
      if (mode == 2 && $urandom_range(3) == 0) begin
        complete = 1'b1;
        if ($urandom_range(3) == 0) complete_id = 3'($urandom);
        else complete_id = 3'(mid);
      end else begin
        complete    = ($urandom_range(31) == 0);
        complete_id = 3'($urandom);
      end
      rst = ($urandom_range(499) == 0);
      step();
    end
    claim = 1'b0; complete = 1'b0; rst = 1'b0;
    idle(3);
    @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d left expected 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
